// File: rtl/mpsoc_wb_raminfr_dp.sv
`default_nettype none
// ============================================================================
// Module   : mpsoc_wb_raminfr_dp
// Purpose  : Dual-port inferred RAM (port a write/read, port dpra read) with
//            lane write enables, async or registered dpra read, write-first
//            collision bypass and a clear sweep sequencer.
//            Define MPSOC_WB_RAMINFR_PARITY_EN for per-lane even parity + perr.
// Revision : 1.0  initial release
// ============================================================================
module mpsoc_wb_raminfr_dp #(
  parameter int                    ADDR_WIDTH     = 4,
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    LANE_WIDTH     = 8,
  parameter int                    DEPTH          = 16,
  parameter int                    READ_LATENCY   = 0,
  parameter int                    CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0,
  localparam int                   LANES          = DATA_WIDTH / LANE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  output logic                  busy,
  input  logic                  we,
  input  logic [LANES-1:0]      be,
  input  logic [ADDR_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] di,
  output logic [DATA_WIDTH-1:0] spo,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] dpra,
  output logic [DATA_WIDTH-1:0] dpo,
  output logic                  perr
);

  localparam int                    IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic [DATA_WIDTH-1:0]   ram [DEPTH];

  logic                    a_ok, dpra_ok, wr_ok;
  logic [IW-1:0]           a_idx, d_idx, cnt_idx;
  logic [DATA_WIDTH-1:0]   ram_a, ram_d, byp_d;
  logic [LANES-1:0]        hit;
  logic                    perr_d, perr_byp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (clr) begin
            state <= S_CLEAR;
            cnt   <= '0;
          end
        end
        S_CLEAR: begin
          if (cnt == LAST_ADDR) state <= S_IDLE;
          else                  cnt   <= cnt + ADDR_WIDTH'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy    = (state == S_CLEAR);
  assign a_ok    = ({1'b0, a} < DEPTH_EXT);
  assign dpra_ok = ({1'b0, dpra} < DEPTH_EXT);
  assign wr_ok   = we && !busy && a_ok;
  assign a_idx   = a[IW-1:0];
  assign d_idx   = dpra[IW-1:0];
  assign cnt_idx = cnt[IW-1:0];

  always_ff @(posedge clk) begin
    if (busy) begin
      ram[cnt_idx] <= CLEAR_VALUE;
    end else if (wr_ok) begin
      for (int i = 0; i < LANES; i++)
        if (be[i]) ram[a_idx][i*LANE_WIDTH +: LANE_WIDTH] <= di[i*LANE_WIDTH +: LANE_WIDTH];
    end
  end

  assign ram_a = a_ok    ? ram[a_idx] : '0;
  assign ram_d = dpra_ok ? ram[d_idx] : '0;
  assign spo   = busy ? CLEAR_VALUE : ram_a;

  // Write-first view of ram[dpra]: lanes being written this cycle return di.
  assign hit = (wr_ok && (a == dpra)) ? be : '0;
  always_comb begin
    byp_d = ram_d;
    for (int i = 0; i < LANES; i++)
      if (hit[i]) byp_d[i*LANE_WIDTH +: LANE_WIDTH] = di[i*LANE_WIDTH +: LANE_WIDTH];
  end

`ifdef MPSOC_WB_RAMINFR_PARITY_EN
  function automatic logic [LANES-1:0] lane_par(input logic [DATA_WIDTH-1:0] d);
    logic [LANES-1:0] p;
    p = '0;
    for (int i = 0; i < LANES; i++) p[i] = ^d[i*LANE_WIDTH +: LANE_WIDTH];
    return p;
  endfunction

  logic [LANES-1:0] ram_par [DEPTH];
  logic [LANES-1:0] par_d, par_byp;

  always_ff @(posedge clk) begin
    if (busy) begin
      ram_par[cnt_idx] <= lane_par(CLEAR_VALUE);
    end else if (wr_ok) begin
      for (int i = 0; i < LANES; i++)
        if (be[i]) ram_par[a_idx][i] <= ^di[i*LANE_WIDTH +: LANE_WIDTH];
    end
  end

  assign par_d    = ram_par[d_idx];
  assign par_byp  = (par_d & ~hit) | (lane_par(di) & hit);
  assign perr_d   = dpra_ok && (|(par_d ^ lane_par(ram_d)));
  assign perr_byp = dpra_ok && (|(par_byp ^ lane_par(byp_d)));
`else
  assign perr_d   = 1'b0;
  assign perr_byp = 1'b0;
`endif

  generate
    if (READ_LATENCY == 0) begin : g_async_read
      logic unused_sync;
      assign unused_sync = ^{re, byp_d, perr_byp};
      assign dpo  = busy ? CLEAR_VALUE : ram_d;
      assign perr = busy ? 1'b0 : perr_d;
    end else begin : g_sync_read
      logic [DATA_WIDTH-1:0] dpo_q;
      logic                  perr_q;
      logic                  unused_async;
      assign unused_async = perr_d;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dpo_q  <= '0;
          perr_q <= 1'b0;
        end else if (re) begin
          dpo_q  <= busy ? CLEAR_VALUE : byp_d;
          perr_q <= busy ? 1'b0 : perr_byp;
        end
      end

      assign dpo  = busy ? CLEAR_VALUE : dpo_q;
      assign perr = busy ? 1'b0 : perr_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mpsoc_wb_raminfr_dp.sv
`default_nettype none
// ============================================================================
// Module   : tb_mpsoc_wb_raminfr_dp
// Purpose  : Scoreboard bench: async-read and registered-read instances share
//            stimulus; a behavioural RAM model predicts every visible output.
// Revision : 1.0  initial release
// ============================================================================
module tb_mpsoc_wb_raminfr_dp;

  localparam int             AW  = 5;
  localparam int             DW  = 32;
  localparam int             LN  = 4;
  localparam int             DEP = 16;
  localparam logic [DW-1:0]  CV  = 32'hC35A_0FF0;

  logic          clk = 1'b0;
  logic          rst, clr, we, re;
  logic [LN-1:0] be;
  logic [AW-1:0] a, dpra;
  logic [DW-1:0] di;
  logic          busy0, busy1, perr0, perr1;
  logic [DW-1:0] spo0, spo1, dpo0, dpo1;

  always #5 clk = ~clk;

  mpsoc_wb_raminfr_dp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LANE_WIDTH(8), .DEPTH(DEP),
    .READ_LATENCY(0), .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV)) u_dut0 (
    .clk(clk), .rst(rst), .clr(clr), .busy(busy0), .we(we), .be(be), .a(a), .di(di),
    .spo(spo0), .re(re), .dpra(dpra), .dpo(dpo0), .perr(perr0));

  mpsoc_wb_raminfr_dp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LANE_WIDTH(8), .DEPTH(DEP),
    .READ_LATENCY(1), .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV)) u_dut1 (
    .clk(clk), .rst(rst), .clr(clr), .busy(busy1), .we(we), .be(be), .a(a), .di(di),
    .spo(spo1), .re(re), .dpra(dpra), .dpo(dpo1), .perr(perr1));

  typedef struct {
    logic          busy;
    logic [DW-1:0] spo;
    logic [DW-1:0] dpo0;
    logic [DW-1:0] dpo1;
    logic          perr0;
    logic          perr1;
  } exp_t;

  exp_t          sb[$];
  int            n_checks = 0;
  int            n_fail   = 0;

  // Reference model: plain array, remaining-sweep counter, registered-read value.
  logic [DW-1:0] m_mem  [DEP];
  bit            m_flip [DEP];
  int            m_busy_rem = DEP;
  logic [DW-1:0] m_dpo1     = '0;
  bit            m_perr1    = 1'b0;

  task automatic model_edge();
    bit            pre_busy;
    int            ia, id;
    pre_busy = (m_busy_rem > 0);
    ia = int'(a);
    id = int'(dpra);
    if (re) begin
      if (pre_busy) begin
        m_dpo1 = CV; m_perr1 = 1'b0;
      end else if (id >= DEP) begin
        m_dpo1 = '0; m_perr1 = 1'b0;
      end else begin
        m_dpo1  = m_mem[id];
        m_perr1 = m_flip[id];
        if (we && ia == id)
          for (int i = 0; i < LN; i++)
            if (be[i]) begin
              m_dpo1[i*8 +: 8] = di[i*8 +: 8];
              if (i == 0) m_perr1 = 1'b0;
            end
      end
    end
    if (pre_busy) begin
      m_mem[DEP - m_busy_rem]  = CV;
      m_flip[DEP - m_busy_rem] = 1'b0;
      m_busy_rem--;
    end else begin
      if (we && ia < DEP)
        for (int i = 0; i < LN; i++)
          if (be[i]) begin
            m_mem[ia][i*8 +: 8] = di[i*8 +: 8];
            if (i == 0) m_flip[ia] = 1'b0;
          end
      if (clr) m_busy_rem = DEP;
    end
  endtask

  function automatic exp_t expect_now();
    exp_t e;
    e.busy  = (m_busy_rem > 0);
    e.spo   = e.busy ? CV : ((int'(a) < DEP) ? m_mem[int'(a)] : '0);
    e.dpo0  = e.busy ? CV : ((int'(dpra) < DEP) ? m_mem[int'(dpra)] : '0);
    e.perr0 = !e.busy && (int'(dpra) < DEP) && m_flip[int'(dpra)];
    e.dpo1  = e.busy ? CV : m_dpo1;
    e.perr1 = !e.busy && m_perr1;
    return e;
  endfunction

  // One clock: apply the previous edge to the model, drive new inputs, predict.
  task automatic cycle(input logic n_rst, input logic n_clr, input logic n_we,
                       input logic n_re, input logic [LN-1:0] n_be, input logic [AW-1:0] n_a,
                       input logic [AW-1:0] n_dpra, input logic [DW-1:0] n_di,
                       input bit flip = 1'b0);
    @(negedge clk);
    if (!rst) model_edge();
    rst = n_rst; clr = n_clr; we = n_we; re = n_re;
    be = n_be; a = n_a; dpra = n_dpra; di = n_di;
    if (rst) begin
      m_busy_rem = DEP; m_dpo1 = '0; m_perr1 = 1'b0;
    end
`ifdef MPSOC_WB_RAMINFR_PARITY_EN
    if (flip) begin
      u_dut0.ram[2][0] = ~u_dut0.ram[2][0];
      u_dut1.ram[2][0] = ~u_dut1.ram[2][0];
      m_mem[2][0]      = ~m_mem[2][0];
      m_flip[2]        = 1'b1;
    end
`else
    if (flip) m_flip[2] = m_flip[2];
`endif
    sb.push_back(expect_now());
  endtask

  task automatic idle(input int n, input logic n_re, input logic [AW-1:0] n_dpra);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, n_re, '0, AW'(k % DEP), n_dpra, '0);
  endtask

  task automatic rand_cycle(input int clr_odds);
    logic [AW-1:0] ra;
    ra = AW'($urandom_range(0, 19));
    cycle(1'b0, 1'($urandom_range(0, clr_odds) == 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), LN'($urandom),
          ra, ($urandom_range(0, 2) == 0) ? ra : AW'($urandom_range(0, 19)), $urandom);
  endtask

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: outputs are sampled 1 ns before each rising edge.
  always @(negedge clk) begin
    exp_t e;
    #4;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("busy0", DW'(busy0), DW'(e.busy));
      chk("busy1", DW'(busy1), DW'(e.busy));
      chk("spo0",  spo0, e.spo);
      chk("spo1",  spo1, e.spo);
      chk("dpo_async", dpo0, e.dpo0);
      chk("dpo_reg",   dpo1, e.dpo1);
      chk("perr_async", DW'(perr0), DW'(e.perr0));
      chk("perr_reg",   DW'(perr1), DW'(e.perr1));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEP; i++) begin m_mem[i] = '0; m_flip[i] = 1'b0; end
    rst = 1'b1; clr = 1'b0; we = 1'b0; re = 1'b0;
    be = '0; a = '0; dpra = '0; di = '0;

    // Reset, then the automatic 16-cycle sweep with reads in flight.
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    for (int k = 0; k < 20; k++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'hF, AW'(k % DEP), AW'(k % DEP), 32'hDEAD_0000 + k);
    idle(DEP, 1'b1, '0);

    // Lane merge: 0xAABBCCDD full, then 0x11223344 lanes 0 and 2 -> 0xAA22CC44.
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 5'd3, 5'd0, 32'hAABB_CCDD);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'b0101, 5'd3, 5'd0, 32'h1122_3344);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 5'd3, 5'd3, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 5'd0, 5'd3, 32'h0);

    // Write-first collision on lane 0, then re low so the register holds.
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'b0001, 5'd5, 5'd5, 32'h0000_005A);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 5'd5, 5'd5, 32'h1234_5678);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 5'd6, 5'd7, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 5'd6, 5'd5, 32'h0);

    // Random traffic including out-of-range addresses and occasional clr.
    for (int k = 0; k < 300; k++) rand_cycle(60);

    // clr mid-traffic with writes and a second clr during the sweep.
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 5'd1, 5'd1, 32'h0BAD_F00D);
    for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'hF, AW'(k), AW'(k), $urandom);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 5'd9, 5'd9, $urandom);
    for (int k = 0; k < 14; k++) rand_cycle(1000);
    idle(DEP, 1'b1, 5'd9);

    // Reset at sweep cycle 7, then full restart; dpra beyond DEPTH reads 0.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
    for (int k = 0; k < 7; k++) rand_cycle(1000);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    for (int k = 0; k < 20; k++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 5'd20, 5'd20, $urandom);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 5'd4, 5'd20, 32'h7777_8888);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 5'd4, 5'd4, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 5'd4, 5'd20, 32'h0);

    // Stored-bit corruption at address 2 (visible only with lane parity).
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 5'd2, 5'd2, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 5'd2, 5'd3, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 5'd2, 5'd2, 32'h0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'b0001, 5'd2, 5'd2, 32'h0000_00A5);
    for (int k = 0; k < 100; k++) rand_cycle(60);
    idle(2, 1'b0, '0);

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    #5;
    if (sb.size() > 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
